// File: rtl/rpn_evaluator_if.sv
// Evaluator bus: start/x/token_count request, token fetch port, busy/done/result/error status.
interface rpn_evaluator_if #(
    parameter int NUMBER_WIDTH = 16
);
    logic                    start;
    logic [NUMBER_WIDTH-1:0] x;
    logic [5:0]              token_count;
    logic [5:0]              token_addr;
    logic [NUMBER_WIDTH:0]   token;
    logic                    busy;
    logic                    done;
    logic [NUMBER_WIDTH-1:0] result;
    logic [2:0]              error;

    modport master (output start, x, token_count, token,
                    input  token_addr, busy, done, result, error);
    modport slave  (input  start, x, token_count, token,
                    output token_addr, busy, done, result, error);
endinterface

// File: rtl/rpn_evaluator.sv
// Q8.8 RPN evaluator: fetches tokens from an external queue and runs a small operand stack.
// Define RPN_EVALUATOR_POW_EN to build the POW operator (iterative saturating multiply).
module rpn_evaluator #(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int NUMBER_WIDTH          = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    parameter int OUTPUT_QUEUE_SIZE     = 64,
    parameter int STACK_SIZE            = 16
) (
    input  logic           clk,
    input  logic           rst,
    rpn_evaluator_if.slave bus
);
    localparam int NW = NUMBER_WIDTH;
    localparam int FW = FRACTIONAL_PART_WIDTH;
    localparam int IW = INTEGER_PART_WIDTH;
    localparam int DW = NW + FW;
    localparam int QW = $clog2(OUTPUT_QUEUE_SIZE);
    localparam int AW = $clog2(STACK_SIZE);
    localparam int SW = $clog2(STACK_SIZE + 1);
    localparam int CW = $clog2(DW + 1);

    localparam logic signed [NW-1:0] MAX_POS = {1'b0, {(NW-1){1'b1}}};
    localparam logic signed [NW-1:0] MAX_NEG = {1'b1, {(NW-1){1'b0}}};
    localparam logic [2:0] OP_PLUS = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_POW  = 3'd4;
    localparam logic [2:0] OP_VAR  = 3'd6;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, DIV_ITER, POW_ITER, DONE} state_t;

    function automatic logic signed [NW-1:0] sat(input logic signed [2*NW-1:0] v);
        logic signed [2*NW-1:0] hi;
        logic signed [2*NW-1:0] lo;
        hi = {{NW{1'b0}}, MAX_POS};
        lo = {{NW{1'b1}}, MAX_NEG};
        if (v > hi)      return MAX_POS;
        else if (v < lo) return MAX_NEG;
        else             return v[NW-1:0];
    endfunction

    state_t               state, state_nxt;
    logic [SW-1:0]        sp;
    logic [QW-1:0]        idx, tok_cnt;
    logic [NW-1:0]        xr;
    logic                 busy, done;
    logic [NW-1:0]        result;
    logic [2:0]           err;
    logic signed [NW-1:0] stack [STACK_SIZE];

    // restoring divider state
    logic [DW-1:0]        dvd, quo, quo_n;
    logic [NW-1:0]        dvs, rem, rem_n;
    logic [NW:0]          rem_sh;
    logic                 neg, div_ge, div_last;
    logic [CW-1:0]        cnt;
    logic signed [NW-1:0] div_res;

    logic                 is_num, last, tok_fin;
    logic [2:0]           op, exec_err;
    logic [AW-1:0]        top_i, nxt_i;
    logic signed [NW-1:0] opa, opb, alu_res;
    logic signed [2*NW-1:0] ea, eb;
    logic [NW-1:0]        a_mag, b_mag;
    logic                 stk_we;
    logic [AW-1:0]        stk_wa;
    logic signed [NW-1:0] stk_wd;

`ifdef RPN_EVALUATOR_POW_EN
    logic [IW-1:0]          pow_n, pcnt;
    logic signed [NW-1:0]   acc, base, pow_res;
    logic signed [2*NW-1:0] eacc, ebase;
    assign pow_n   = opb[NW-1:FW];
    assign eacc    = acc;
    assign ebase   = base;
    assign pow_res = sat((eacc * ebase) >>> FW);
`endif

    assign is_num = ~bus.token[NW];
    assign op     = bus.token[2:0];
    assign top_i  = AW'(sp - 1'b1);
    assign nxt_i  = AW'(sp - 2'd2);
    assign opb    = stack[top_i];
    assign opa    = stack[nxt_i];
    assign ea     = opa;
    assign eb     = opb;
    assign a_mag  = opa[NW-1] ? NW'(-opa) : opa;
    assign b_mag  = opb[NW-1] ? NW'(-opb) : opb;
    assign last   = ({1'b0, idx} + 1'b1) == {1'b0, tok_cnt};

    always_comb begin
        alu_res = sat((ea * eb) >>> FW);
        if (op == OP_PLUS)     alu_res = sat(ea + eb);
        else if (op == OP_SUB) alu_res = sat(ea - eb);
    end

    assign rem_sh   = {rem, dvd[DW-1]};
    assign div_ge   = rem_sh >= {1'b0, dvs};
    assign rem_n    = NW'(div_ge ? rem_sh - {1'b0, dvs} : rem_sh);
    assign quo_n    = {quo[DW-2:0], div_ge};
    assign div_last = cnt == CW'(DW - 1);

    always_comb begin
        if (neg)
            div_res = (quo_n > {{FW{1'b0}}, 1'b1, {(NW-1){1'b0}}}) ? MAX_NEG : -quo_n[NW-1:0];
        else
            div_res = (quo_n > {{(FW+1){1'b0}}, {(NW-1){1'b1}}}) ? MAX_POS : quo_n[NW-1:0];
    end

    always_comb begin
        exec_err = 3'd0;
        if (is_num || op == OP_VAR) begin
            if (sp == SW'(STACK_SIZE)) exec_err = 3'd1;
        end else if (op == OP_PLUS || op == OP_SUB || op == OP_MUL || op == OP_DIV) begin
            if (sp < SW'(2))                  exec_err = 3'd2;
            else if (op == OP_DIV && opb == '0) exec_err = 3'd3;
        end
`ifdef RPN_EVALUATOR_POW_EN
        else if (op == OP_POW) begin
            if (sp < SW'(2))   exec_err = 3'd2;
            else if (opb[NW-1]) exec_err = 3'd4;
        end
`endif
        else exec_err = 3'd4;
    end

    // tok_fin marks the cycle a token's result lands on the stack
    always_comb begin
        tok_fin = 1'b0;
        stk_we  = 1'b0;
        stk_wa  = nxt_i;
        stk_wd  = alu_res;
        case (state)
            EXEC: if (exec_err == 3'd0) begin
                if (is_num || op == OP_VAR) begin
                    tok_fin = 1'b1;
                    stk_we  = 1'b1;
                    stk_wa  = sp[AW-1:0];
                    stk_wd  = is_num ? bus.token[NW-1:0] : xr;
                end else if (op != OP_DIV) begin
`ifdef RPN_EVALUATOR_POW_EN
                    if (op == OP_POW) begin
                        if (pow_n <= IW'(1)) begin
                            tok_fin = 1'b1;
                            stk_we  = 1'b1;
                            stk_wd  = (pow_n == '0) ? {{(IW-1){1'b0}}, 1'b1, {FW{1'b0}}} : opa;
                        end
                    end else
`endif
                    begin
                        tok_fin = 1'b1;
                        stk_we  = 1'b1;
                    end
                end
            end
            DIV_ITER: if (div_last) begin
                tok_fin = 1'b1;
                stk_we  = 1'b1;
                stk_wa  = top_i;
                stk_wd  = div_res;
            end
`ifdef RPN_EVALUATOR_POW_EN
            POW_ITER: if (pcnt == IW'(1)) begin
                tok_fin = 1'b1;
                stk_we  = 1'b1;
                stk_wa  = top_i;
                stk_wd  = pow_res;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = FETCH;
            FETCH: state_nxt = (tok_cnt == '0) ? DONE : WAIT;
            WAIT:  state_nxt = EXEC;
            EXEC: begin
                if (exec_err != 3'd0) state_nxt = DONE;
                else if (tok_fin)     state_nxt = last ? DONE : FETCH;
                else if (op == OP_DIV) state_nxt = DIV_ITER;
`ifdef RPN_EVALUATOR_POW_EN
                else                  state_nxt = POW_ITER;
`endif
            end
            DIV_ITER: if (tok_fin) state_nxt = last ? DONE : FETCH;
`ifdef RPN_EVALUATOR_POW_EN
            POW_ITER: if (tok_fin) state_nxt = last ? DONE : FETCH;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (stk_we) stack[stk_wa] <= stk_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp     <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    xr      <= bus.x;
                    tok_cnt <= bus.token_count;
                    sp      <= '0;
                    idx     <= '0;
                    result  <= '0;
                    err     <= 3'd0;
                    busy    <= 1'b1;
                end
                EXEC: begin
                    if (exec_err != 3'd0) err <= exec_err;
                    else if (is_num || op == OP_VAR) sp <= sp + 1'b1;
                    else sp <= sp - 1'b1;
                    // binary ops pop here; deferred results later overwrite operand a's slot
                    if (exec_err == 3'd0 && !is_num && op == OP_DIV) begin
                        dvd <= {a_mag, {FW{1'b0}}};
                        dvs <= b_mag;
                        rem <= '0;
                        quo <= '0;
                        cnt <= '0;
                        neg <= opa[NW-1] ^ opb[NW-1];
                    end
`ifdef RPN_EVALUATOR_POW_EN
                    if (exec_err == 3'd0 && !is_num && op == OP_POW) begin
                        acc  <= opa;
                        base <= opa;
                        pcnt <= IW'(pow_n - 1'b1);
                    end
`endif
                end
                DIV_ITER: begin
                    dvd <= dvd << 1;
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                end
`ifdef RPN_EVALUATOR_POW_EN
                POW_ITER: begin
                    acc  <= pow_res;
                    pcnt <= pcnt - 1'b1;
                end
`endif
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (err == 3'd0) begin
                        if (sp == SW'(1)) result <= stack[0];
                        else              err    <= 3'd5;
                    end
                end
                default: ;
            endcase
            if (tok_fin) idx <= idx + 1'b1;
        end
    end

    assign bus.token_addr = idx;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.result     = result;
    assign bus.error      = err;
endmodule

// File: tb/tb_rpn_evaluator.sv
// Bench for rpn_evaluator: directed cases plus random programs scored against a queue-based model.
module tb_rpn_evaluator;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    logic [16:0] mem [64];

    rpn_evaluator_if #(.NUMBER_WIDTH(16)) bif();
    rpn_evaluator dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;
    always @(posedge clk) bif.token <= mem[bif.token_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] num(input logic [15:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [16:0] opr(input logic [2:0] o);
        return {1'b1, 13'd0, o};
    endfunction

    function automatic int sx(input logic [15:0] v);
        int r;
        r = $signed(v);
        return r;
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: evaluate mem[0..n-1] with an int queue as the stack; cyc=-1 means no timing expectation.
    task automatic ref_eval(input int n, input int xv, output int res, output int err, output int cyc);
        int stk[$];
        int a, b, p, acc;
        logic [16:0] t;
        err = 0; res = 0; cyc = 1;
        for (int i = 0; i < n && err == 0; i++) begin
            t = mem[i];
            cyc += 3;
            if (!t[16] || t[2:0] == 3'd6) begin
                if (stk.size() == 16) err = 1;
                else stk.push_back(t[16] ? xv : sx(t[15:0]));
            end else if (t[2:0] <= 3'd3) begin
                if (stk.size() < 2) err = 2;
                else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    case (t[2:0])
                        3'd0: stk.push_back(clamp(a + b));
                        3'd1: stk.push_back(clamp(a - b));
                        3'd2: stk.push_back(clamp((a * b) >>> 8));
                        default: begin
                            if (b == 0) err = 3;
                            else begin
                                stk.push_back(clamp((a * 256) / b));
                                cyc += 24;
                            end
                        end
                    endcase
                end
            end
`ifdef RPN_EVALUATOR_POW_EN
            else if (t[2:0] == 3'd4) begin
                if (stk.size() < 2) err = 2;
                else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    p = b >>> 8;
                    if (p < 0) err = 4;
                    else if (p == 0) stk.push_back(256);
                    else begin
                        acc = a;
                        for (int j = 1; j < p; j++) acc = clamp((acc * a) >>> 8);
                        cyc += p - 1;
                        stk.push_back(acc);
                    end
                end
            end
`endif
            else err = 4;
        end
        if (err == 0) begin
            if (stk.size() == 1) res = stk[0] & 32'hFFFF;
            else err = 5;
        end
        if (n == 0) cyc = -1;
    endtask

    task automatic run_prog(input string tag, input int n, input logic [15:0] xv,
                            output int res, output int err, output int cyc, output bit ok);
        logic got;
        @(negedge clk);
        bif.start = 1'b1;
        bif.x = xv;
        bif.token_count = 6'(n);
        @(posedge clk); #1;
        bif.start = 1'b0;
        chk({tag, "_busy"}, bif.busy, 1);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            got = bif.done;
        end
        chk({tag, "_done_seen"}, got, 1);
        ok  = got;
        res = bif.result;
        err = bif.error;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {bif.done, bif.busy}, 2'b00);
    endtask

    task automatic run_dir(input string tag, input int n, input logic [15:0] xv,
                           input int exp_res, input int exp_err, input int exp_cyc);
        int res, err, cyc;
        bit ok;
        run_prog(tag, n, xv, res, err, cyc, ok);
        if (ok) begin
            chk({tag, "_result"}, res, exp_res);
            chk({tag, "_error"}, err, exp_err);
            if (exp_cyc >= 0) chk({tag, "_cycles"}, cyc, exp_cyc);
        end
    endtask

    function automatic logic [15:0] rnd_num();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 16'($urandom);
        if (r < 3) return 16'h0000;
        return 16'($urandom_range(0, 4095) - 2048);
    endfunction

    task automatic gen_prog(output int n);
        int d, r;
        n = $urandom_range(1, 20);
        d = 0;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) mem[i] = opr(3'($urandom_range(0, 7)));
            else if (d < 2 || r < 45) begin
                mem[i] = (r % 5 == 0) ? opr(3'd6) : num(rnd_num());
                d++;
            end else begin
                r = $urandom_range(0, 9);
                mem[i] = opr(r < 2 ? 3'd0 : r < 4 ? 3'd1 : r < 6 ? 3'd2 : r < 8 ? 3'd3 : 3'd4);
                d--;
            end
        end
    endtask

    initial begin
        int res, err, cyc, er, ee, ec, n;
        bit ok;
        logic [15:0] xv;
        logic saw_done;

        rst = 1'b1;
        bif.start = 1'b0;
        bif.x = '0;
        bif.token_count = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_result", bif.result, 0);
        chk("rst_error", bif.error, 0);
        chk("rst_addr", bif.token_addr, 0);
        @(negedge clk) rst = 1'b0;

        mem[0] = num(16'h0200); mem[1] = num(16'h0300); mem[2] = opr(3'd0);
        run_dir("add", 3, 16'h0, 16'h0500, 0, 10);
        mem[0] = opr(3'd6); mem[1] = num(16'h0080); mem[2] = opr(3'd2);
        run_dir("mul_x", 3, 16'hFE00, 16'hFF00, 0, 10);
        mem[0] = num(16'h7F00); mem[1] = num(16'h7F00); mem[2] = opr(3'd0);
        run_dir("add_sat", 3, 16'h0, 16'h7FFF, 0, 10);
        mem[0] = num(16'h8000); mem[1] = num(16'h0100); mem[2] = opr(3'd1);
        run_dir("sub_sat", 3, 16'h0, 16'h8000, 0, 10);
        mem[0] = num(16'h0100); mem[1] = num(16'h0000); mem[2] = opr(3'd3);
        run_dir("div0", 3, 16'h0, 0, 3, 10);
        mem[0] = num(16'h0300); mem[1] = num(16'h0200); mem[2] = opr(3'd3);
        run_dir("div", 3, 16'h0, 16'h0180, 0, 34);
        mem[0] = num(16'hFD00); mem[1] = num(16'h0200); mem[2] = opr(3'd3);
        run_dir("div_neg", 3, 16'h0, 16'hFE80, 0, 34);
        mem[0] = opr(3'd0);
        run_dir("underflow", 1, 16'h0, 0, 2, 4);
        for (int i = 0; i < 17; i++) mem[i] = num(16'(i));
        run_dir("overflow", 17, 16'h0, 0, 1, 52);
        mem[0] = num(16'h0100); mem[1] = num(16'h0100);
        run_dir("depth2", 2, 16'h0, 0, 5, 7);
        run_dir("empty", 0, 16'h0, 0, 5, -1);
        mem[0] = num(16'h0100); mem[1] = opr(3'd5);
        run_dir("bad_op", 2, 16'h0, 0, 4, 7);
        mem[0] = num(16'h0200); mem[1] = num(16'h0300); mem[2] = opr(3'd4);
`ifdef RPN_EVALUATOR_POW_EN
        run_dir("pow", 3, 16'h0, 16'h0800, 0, 12);
`else
        run_dir("pow", 3, 16'h0, 0, 4, 10);
`endif

        // reset in the middle of a divide
        mem[0] = num(16'h0300); mem[1] = num(16'h0200); mem[2] = opr(3'd3);
        @(negedge clk);
        bif.start = 1'b1;
        bif.token_count = 6'd3;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", bif.busy, 0);
        chk("mid_rst_done", bif.done, 0);
        chk("mid_rst_addr", bif.token_addr, 0);
        @(negedge clk) rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw_done = saw_done | bif.done;
        end
        chk("mid_rst_no_done", saw_done, 0);
        run_dir("after_rst", 3, 16'h0, 16'h0180, 0, 34);

        for (int t = 0; t < 150; t++) begin
            gen_prog(n);
            xv = rnd_num();
            ref_eval(n, sx(xv), er, ee, ec);
            run_prog("rand", n, xv, res, err, cyc, ok);
            if (ok) begin
                chk("rand_result", res, er);
                chk("rand_error", err, ee);
                if (ec >= 0) chk("rand_cycles", cyc, ec);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
